// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: front end for the two-digit BCD stopwatch counter.
// Divides clk down to the slow count clock (tick_clk) and turns the raw,
// bouncy start/stop button into a registered hold request (interrupt).
// Button path: 2-flop synchronizer -> run-length debouncer -> rising-edge
// press pulse -> two-state run/pause toggle. The divider is free-running and
// never stops, so the downstream counter keeps sampling interrupt while paused.

module stopwatch_ctrl #(
    parameter int HALF_PERIOD = 25_000_000,
    parameter int DEB_CYCLES  = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic tick_clk,
    output logic interrupt,
    output logic running,
    output logic press
);

    // state       | meaning
    // ST_PAUSED   | counter held, interrupt = 1 (reset state)
    // ST_RUNNING  | counter counting, interrupt = 0
    typedef enum logic {
        ST_RUNNING = 1'b0,
        ST_PAUSED  = 1'b1
    } run_state_e;

    localparam int DEB_W  = $clog2(DEB_CYCLES);
    localparam int PCNT_W = $clog2(HALF_PERIOD + 1);

    // Last count value before a level change is accepted / tick_clk toggles.
    localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(HALF_PERIOD - 1);

    // synchronizer
    logic s1_q, s1_d;
    logic s2_q, s2_d;

    // debouncer
    logic             db_q, db_d;
    logic [DEB_W-1:0] dcnt_q, dcnt_d;
    logic             accept;

    // press detect and run FSM
    logic       press_q, press_d;
    run_state_e state_q, state_d;
    logic       interrupt_q, interrupt_d;

    // prescaler
    logic [PCNT_W-1:0] pcnt_q, pcnt_d;
    logic              tick_q, tick_d;

    // Synchronizer next state: plain shift, only s2 is used downstream.
    always_comb begin
        s1_d = btn;
        s2_d = s1_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    // Debouncer: a new level is taken only after DEB_CYCLES consecutive
    // samples differ from the current level; any matching sample restarts it.
    always_comb begin
        db_d   = db_q;
        dcnt_d = dcnt_q;
        accept = 1'b0;
        if (s2_q == db_q) begin
            dcnt_d = '0;
        end else if (dcnt_q == DEB_LAST) begin
            db_d   = s2_q;
            dcnt_d = '0;
            accept = 1'b1;
        end else begin
            dcnt_d = dcnt_q + 1'b1;
        end
    end

    // Debouncer flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_q   <= 1'b0;
            dcnt_q <= '0;
        end else begin
            db_q   <= db_d;
            dcnt_q <= dcnt_d;
        end
    end

    // Press pulse and run/pause toggle: an accepted 0->1 level change is a
    // press; accepted releases change nothing here. interrupt is decoded from
    // the next state so that it lands on the same edge as the toggle.
    always_comb begin
        press_d     = accept & s2_q;
        state_d     = state_q;
        if (press_d) begin
            state_d = (state_q == ST_PAUSED) ? ST_RUNNING : ST_PAUSED;
        end
        interrupt_d = (state_d == ST_PAUSED);
    end

    // Run FSM with its registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_PAUSED;
            interrupt_q <= 1'b1;
            press_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            interrupt_q <= interrupt_d;
            press_q     <= press_d;
        end
    end

    // Prescaler: counts 0..HALF_PERIOD-1 and flips tick_clk on wrap, giving a
    // 50% duty clock of period 2*HALF_PERIOD. Runs regardless of run state.
    always_comb begin
        tick_d = tick_q;
        if (pcnt_q == PCNT_LAST) begin
            pcnt_d = '0;
            tick_d = ~tick_q;
        end else begin
            pcnt_d = pcnt_q + 1'b1;
        end
    end

    // Prescaler flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt_q <= '0;
            tick_q <= 1'b0;
        end else begin
            pcnt_q <= pcnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_clk  = tick_q;
    assign interrupt = interrupt_q;
    assign running   = ~interrupt_q;
    assign press     = press_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl (HALF_PERIOD = 3, DEB_CYCLES = 4).
// Table-driven vectors for clean press and bounce, hand sequences for resets,
// toggling and the free-running divider, then random button runs checked
// against a window-based reference model.

module tb_stopwatch_ctrl;

    localparam int HP = 3;
    localparam int DC = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic btn   = 1'b0;
    logic tick_clk, interrupt, running, press;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_model = 1'b0;

    stopwatch_ctrl #(
        .HALF_PERIOD(HP),
        .DEB_CYCLES (DC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn      (btn),
        .tick_clk (tick_clk),
        .interrupt(interrupt),
        .running  (running),
        .press    (press)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // ---------------- reference model ----------------
    // Keeps the raw button value seen at each edge. The synchronized sample
    // used at edge n is the button seen two edges earlier; a new level is
    // accepted when the last DC such samples all differ from the current one.
    bit m_hist[$];
    bit m_db    = 1'b0;
    bit m_int   = 1'b1;
    bit m_press = 1'b0;
    bit m_tick  = 1'b0;
    int m_edges = 0;

    task automatic model_reset();
        m_hist.delete();
        for (int i = 0; i < DC + 2; i++) m_hist.push_back(1'b0);
        m_db    = 1'b0;
        m_int   = 1'b1;
        m_press = 1'b0;
        m_tick  = 1'b0;
        m_edges = 0;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            model_reset();
        end else begin
            bit all_diff;
            m_hist.push_back(btn);
            all_diff = 1'b1;
            for (int j = 0; j < DC; j++)
                if (m_hist[m_hist.size() - 3 - j] == m_db) all_diff = 1'b0;
            m_press = all_diff && !m_db;
            if (all_diff) m_db = !m_db;
            if (m_press) m_int = !m_int;
            m_edges++;
            m_tick = ((m_edges / HP) % 2) == 1;
            void'(m_hist.pop_front());
        end
    end

    always @(negedge clk) begin
        if (chk_model) begin
            chk("rnd tick_clk", tick_clk, m_tick);
            chk("rnd interrupt", interrupt, m_int);
            chk("rnd running", running, !m_int);
            chk("rnd press", press, m_press);
        end
    end

    // ---------------- vector tables ----------------
    typedef struct {
        logic btn;
        logic exp_press;
        logic exp_int;
        logic exp_tick;
        int   exp_dcnt;   // -1: not checked
    } vec_t;

    vec_t clean_v[30];
    vec_t bounce_v[18];
    logic bpat[8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    int   bdc[10] = '{0, 0, 1, 2, 3, 0, 1, 2, 3, 0};

    // Drives one row, advances one clock, checks after the edge.
    task automatic apply_vec(input string tag, input int idx, input vec_t v);
        btn = v.btn;
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("%s[%0d] press", tag, idx), press, v.exp_press);
        chk($sformatf("%s[%0d] interrupt", tag, idx), interrupt, v.exp_int);
        chk($sformatf("%s[%0d] running", tag, idx), running, !v.exp_int);
        chk($sformatf("%s[%0d] tick_clk", tag, idx), tick_clk, v.exp_tick);
        if (v.exp_dcnt >= 0)
            chk($sformatf("%s[%0d] dcnt", tag, idx), dut.dcnt_q, v.exp_dcnt);
    endtask

    // ---------------- observation helpers ----------------
    int cyc_cnt = 0;
    int obs_presses = 0;
    int obs_int[$];
    int obs_rises[$];
    logic last_int, last_tick;

    task automatic obs_clear();
        obs_presses = 0;
        obs_int.delete();
        obs_rises.delete();
        last_int  = interrupt;
        last_tick = tick_clk;
    endtask

    task automatic drive_cycles(input logic lvl, input int n);
        for (int k = 0; k < n; k++) begin
            btn = lvl;
            @(posedge clk);
            @(negedge clk);
            cyc_cnt++;
            if (press) obs_presses++;
            if (interrupt != last_int) begin
                obs_int.push_back(int'(interrupt));
                last_int = interrupt;
            end
            if (tick_clk && !last_tick) obs_rises.push_back(cyc_cnt);
            last_tick = tick_clk;
        end
    endtask

    // Leaves the bench at a falling edge with reset just released; the next
    // rising edge is edge 1 after release.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        btn   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int   run_len;
    logic run_lvl;

    initial begin
        for (int i = 0; i < 30; i++)
            clean_v[i] = '{btn: (i < 20), exp_press: (i == 5), exp_int: (i < 5),
                           exp_tick: (((i + 1) / HP) % 2 == 1), exp_dcnt: -1};
        for (int i = 0; i < 18; i++)
            bounce_v[i] = '{btn: (i < 8) ? bpat[i] : 1'b0, exp_press: 1'b0, exp_int: 1'b1,
                            exp_tick: (((i + 1) / HP) % 2 == 1),
                            exp_dcnt: (i < 10) ? bdc[i] : 0};

        // reset values
        @(negedge clk);
        @(negedge clk);
        chk("reset interrupt", interrupt, 1);
        chk("reset running", running, 0);
        chk("reset tick_clk", tick_clk, 0);
        chk("reset press", press, 0);
        chk("reset dcnt", dut.dcnt_q, 0);

        // clean press then release
        do_reset();
        for (int i = 0; i < 30; i++) apply_vec("clean", i, clean_v[i]);

        // reset mid-count while RUNNING with tick_clk high
        for (int k = 0; k < 10 && tick_clk != 1'b1; k++) drive_cycles(1'b0, 1);
        chk("midrst pre tick_clk", tick_clk, 1);
        chk("midrst pre interrupt", interrupt, 0);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst interrupt", interrupt, 1);
        chk("midrst running", running, 0);
        chk("midrst tick_clk", tick_clk, 0);
        chk("midrst press", press, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("midrst edge%0d tick_clk", k), tick_clk, ((k / HP) % 2));
            chk($sformatf("midrst edge%0d interrupt", k), interrupt, 1);
        end

        // bounce rejection
        do_reset();
        for (int i = 0; i < 18; i++) apply_vec("bounce", i, bounce_v[i]);

        // toggle back: two presses separated by idle time
        do_reset();
        obs_clear();
        drive_cycles(1'b1, 8);
        drive_cycles(1'b0, 15);
        drive_cycles(1'b1, 8);
        drive_cycles(1'b0, 12);
        chk("toggle press count", obs_presses, 2);
        chk("toggle interrupt changes", obs_int.size(), 2);
        if (obs_int.size() >= 2) begin
            chk("toggle first interrupt", obs_int[0], 0);
            chk("toggle second interrupt", obs_int[1], 1);
        end
        chk("toggle enough tick rises", obs_rises.size() >= 6, 1);
        for (int i = 1; i < obs_rises.size(); i++)
            chk($sformatf("toggle tick period %0d", i), obs_rises[i] - obs_rises[i-1], 2 * HP);

        // free-running divider while paused
        obs_clear();
        drive_cycles(1'b0, 60);
        chk("idle tick rises", obs_rises.size(), 10);
        chk("idle interrupt changes", obs_int.size(), 0);
        chk("idle interrupt", interrupt, 1);
        chk("idle presses", obs_presses, 0);

        // reset during qualification
        do_reset();
        btn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("qualrst dcnt before", dut.dcnt_q, 2);
        #1 rst_n = 1'b0;
        #1;
        chk("qualrst interrupt", interrupt, 1);
        chk("qualrst dcnt", dut.dcnt_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("qualrst edge%0d press", k), press, (k == 6));
            chk($sformatf("qualrst edge%0d interrupt", k), interrupt, (k < 6));
        end

        // randomized button runs against the model
        do_reset();
        chk_model = 1'b1;
        run_lvl   = 1'b0;
        for (int r = 0; r < 400; r++) begin
            run_len = $urandom_range(1, 9);
            run_lvl = ($urandom_range(0, 2) == 0) ? run_lvl : ~run_lvl;
            for (int k = 0; k < run_len; k++) begin
                @(negedge clk);
                btn = run_lvl;
            end
            if (r == 200) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        @(negedge clk);
        chk_model = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
